// File: rtl/mem_lsu_if.sv
// Data-memory request/response bus between the load/store unit (master) and data memory (slave).
// Request side is valid/ready; the response side carries no backpressure.
interface mem_lsu_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] addr;
  logic              we;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, addr, we, be, wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, addr, we, be, wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one outstanding access; load 3 cycles min, store 2, misaligned 1.
// Backpressure: req_ready only in IDLE; dmem request held stable until dmem req_ready.
module mem_lsu #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  mem_lsu_if.master         dmem,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [DATA_W-1:0] exc_addr
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, FIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [1:0]        size;
    logic              uns;
    logic              we;
    logic [4:0]        rd;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
  } meta_t;

  state_t            state_q, state_d;
  meta_t             meta_q;
  logic              exc_q;
  logic [1:0]        cause_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              misaligned;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] rsp_shift;
  logic [DATA_W-1:0] ld_ext;
  logic              timeout_hit;

  // Request formatting happens at accept time so the dmem outputs come straight from flops.
  always_comb begin
    misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                 (req_size[1] && (req_addr[1:0] != 2'b00));
    case (req_size)
      2'b00: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << req_addr[1:0];
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
      end
    endcase
  end

  always_comb begin
    rsp_shift = dmem.rsp_rdata >> {meta_q.addr[1:0], 3'b000};
    case (meta_q.size)
      2'b00:   ld_ext = {{24{~meta_q.uns & rsp_shift[7]}}, rsp_shift[7:0]};
      2'b01:   ld_ext = {{16{~meta_q.uns & rsp_shift[15]}}, rsp_shift[15:0]};
      default: ld_ext = rsp_shift;
    endcase
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    dmem.req_valid = 1'b0;
    dmem.addr      = '0;
    dmem.we        = 1'b0;
    dmem.be        = 4'b0000;
    dmem.wdata     = '0;
    done           = 1'b0;
    wb_valid       = 1'b0;
    exc_valid      = 1'b0;
    exc_cause      = 2'b00;
    exc_addr       = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = misaligned ? FIN : REQ;
      end
      REQ: begin
        dmem.req_valid = 1'b1;
        dmem.addr      = {meta_q.addr[DATA_W-1:2], 2'b00};
        dmem.we        = meta_q.we;
        dmem.be        = meta_q.be;
        dmem.wdata     = meta_q.wdata;
        if (dmem.req_ready) state_d = meta_q.we ? FIN : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (dmem.rsp_valid || timeout_hit) state_d = FIN;
      end
      FIN: begin
        done      = 1'b1;
        wb_valid  = ~exc_q & ~meta_q.we;
        exc_valid = exc_q;
        exc_cause = exc_q ? cause_q : 2'b00;
        exc_addr  = exc_q ? meta_q.addr : '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= '0;
      exc_q   <= 1'b0;
      cause_q <= 2'b00;
      cnt_q   <= '0;
      wb_data <= '0;
      wb_rd   <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          meta_q  <= '{addr: req_addr, size: req_size, uns: req_unsigned, we: req_we,
                       rd: req_rd, be: st_be, wdata: st_wdata};
          exc_q   <= misaligned;
          cause_q <= req_we ? 2'b10 : 2'b01;
        end
        REQ: cnt_q <= '0;
        WAIT_RSP: begin
          if (dmem.rsp_valid) begin
            wb_data <= ld_ext;
            wb_rd   <= meta_q.rd;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (timeout_hit) begin
              exc_q   <= 1'b1;
              cause_q <= 2'b11;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: directed and random accesses against a byte-level reference model.
module tb_mem_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        wb_valid, done, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [1:0]  exc_cause;

  int n_chk  = 0;
  int n_fail = 0;

  mem_lsu_if #(.DATA_W(32)) dmem_if ();

  mem_lsu #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .dmem(dmem_if.master),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .done(done), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: accesses described as a run of bytes starting at addr%4.
  function automatic int m_nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input int nb, input int off);
    logic [3:0] be = 4'b0000;
    for (int i = 0; i < nb; i++) be[off+i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int nb);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input int nb, input bit uns,
                                         input int off);
    longint v = 0;
    for (int i = 0; i < nb; i++) v += longint'((rd >> (8 * (off + i))) & 32'hFF) << (8 * i);
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
    return v[31:0];
  endfunction

  task automatic check_idle_outputs(input string pfx);
    chk({pfx, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({pfx, "_dmem_req_valid"}, {31'd0, dmem_if.req_valid}, 32'd0);
    chk({pfx, "_dmem_addr"}, dmem_if.addr, 32'd0);
    chk({pfx, "_dmem_be_we"}, {27'd0, dmem_if.we, dmem_if.be}, 32'd0);
    chk({pfx, "_dmem_wdata"}, dmem_if.wdata, 32'd0);
    chk({pfx, "_pulses"}, {29'd0, done, wb_valid, exc_valid}, 32'd0);
    chk({pfx, "_wb"}, wb_data | {27'd0, wb_rd}, 32'd0);
    chk({pfx, "_exc"}, exc_addr | {30'd0, exc_cause}, 32'd0);
  endtask

  // One access from accept to retire; called #1 after a rising edge with the unit idle.
  task automatic do_op(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input int rdy_dly, input int rsp_dly, input bit give_rsp,
                       input logic [31:0] rdata);
    int nb, off, hs_c, req_cyc, t_done, t_exp, wb_cnt, exc_cnt;
    bit mis, unstable, exp_wb, exp_exc;
    logic [31:0] a0, d0, wbd, ea;
    logic [3:0]  be0;
    logic        we0;
    logic [4:0]  wbr;
    logic [1:0]  ec, exp_cause;
    nb = m_nbytes(sz);
    off = int'(addr % 4);
    mis = (off % nb) != 0;
    hs_c = 0; req_cyc = 0; t_done = 0; wb_cnt = 0; exc_cnt = 0; unstable = 0;
    a0 = '0; d0 = '0; be0 = '0; we0 = 0; wbd = '0; wbr = '0; ec = '0; ea = '0;
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    tick();
    req_valid = 0; req_we = ~we; req_size = ~sz; req_unsigned = ~uns;
    req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    for (int c = 1; c <= 60 && t_done == 0; c++) begin
      dmem_if.req_ready = 0;
      dmem_if.rsp_valid = 0;
      if (dmem_if.req_valid) begin
        req_cyc++;
        if (req_cyc == 1) begin
          a0 = dmem_if.addr; d0 = dmem_if.wdata; be0 = dmem_if.be; we0 = dmem_if.we;
        end else if (a0 !== dmem_if.addr || d0 !== dmem_if.wdata || be0 !== dmem_if.be ||
                     we0 !== dmem_if.we) begin
          unstable = 1;
        end
        if (req_cyc > rdy_dly) begin
          dmem_if.req_ready = 1;
          hs_c = c;
          // A response alongside the request handshake must be ignored.
          dmem_if.rsp_valid = 1;
          dmem_if.rsp_rdata = ~rdata;
        end
      end
      if (give_rsp && hs_c > 0 && c == hs_c + rsp_dly) begin
        dmem_if.rsp_valid = 1;
        dmem_if.rsp_rdata = rdata;
      end
      if (wb_valid) wb_cnt++;
      if (exc_valid) exc_cnt++;
      if (done) begin
        t_done = c; wbd = wb_data; wbr = wb_rd; ec = exc_cause; ea = exc_addr;
      end
      tick();
    end
    dmem_if.req_ready = 0;
    dmem_if.rsp_valid = 0;

    exp_wb  = !mis && !we && give_rsp;
    exp_exc = mis || (!we && !give_rsp);
    exp_cause = mis ? (we ? 2'b10 : 2'b01) : 2'b11;
    if (mis)           t_exp = 1;
    else if (we)       t_exp = rdy_dly + 2;
    else if (give_rsp) t_exp = rdy_dly + rsp_dly + 2;
    else               t_exp = rdy_dly + TO + 2;

    chk("done_cycle", t_done, t_exp);
    chk("dmem_req_issued", {31'd0, req_cyc > 0}, {31'd0, !mis});
    if (!mis) begin
      chk("dmem_req_cycles", req_cyc, rdy_dly + 1);
      chk("dmem_addr", a0, addr & ~32'd3);
      chk("dmem_be", {28'd0, be0}, {28'd0, m_be(nb, off)});
      chk("dmem_we", {31'd0, we0}, {31'd0, we});
      if (we) chk("dmem_wdata", d0, m_wdata(wdata, nb));
      chk("dmem_stable", {31'd0, unstable}, 32'd0);
    end
    chk("wb_pulses", wb_cnt, exp_wb ? 1 : 0);
    if (exp_wb) begin
      chk("wb_data", wbd, m_load(rdata, nb, uns, off));
      chk("wb_rd", {27'd0, wbr}, {27'd0, rd});
    end
    chk("exc_pulses", exc_cnt, exp_exc ? 1 : 0);
    if (exp_exc) begin
      chk("exc_cause", {30'd0, ec}, {30'd0, exp_cause});
      chk("exc_addr", ea, addr);
    end
    chk("after_fin_ready", {30'd0, req_ready, done}, 32'd2);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rsz;
    rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; req_rd = 0;
    dmem_if.req_ready = 0; dmem_if.rsp_valid = 0; dmem_if.rsp_rdata = 0;
    tick();
    tick();
    rst = 0;
    check_idle_outputs("reset");

    // Word loads, response in the first and second wait cycle
    do_op(0, 2'b10, 0, 32'h100, 32'h0, 5'd7, 0, 1, 1, 32'hDEADBEEF);
    do_op(0, 2'b10, 0, 32'h100, 32'h0, 5'd9, 0, 2, 1, 32'hDEADBEEF);
    // Byte loads, signed and unsigned, from the top lane
    do_op(0, 2'b00, 0, 32'h103, 32'h0, 5'd3, 0, 1, 1, 32'h80FF_0000);
    do_op(0, 2'b00, 1, 32'h103, 32'h0, 5'd4, 0, 1, 1, 32'h80FF_0000);
    // Half loads from the upper half, sign and zero
    do_op(0, 2'b01, 0, 32'h2, 32'h0, 5'd5, 1, 3, 1, 32'h9234_0000);
    do_op(0, 2'b01, 1, 32'h2, 32'h0, 5'd6, 0, 1, 1, 32'h9234_0000);
    // Half store held off by 5 cycles of dmem backpressure, then without
    do_op(1, 2'b01, 0, 32'h202, 32'h1234_ABCD, 5'd0, 5, 1, 0, 32'h0);
    do_op(1, 2'b01, 0, 32'h202, 32'h1234_ABCD, 5'd0, 0, 1, 0, 32'h0);
    do_op(1, 2'b00, 0, 32'h41, 32'h0000_00A5, 5'd0, 0, 1, 0, 32'h0);
    // Misaligned load and store
    do_op(0, 2'b10, 0, 32'h101, 32'h0, 5'd1, 0, 1, 1, 32'h1);
    do_op(1, 2'b01, 0, 32'h003, 32'h5555, 5'd1, 0, 1, 0, 32'h0);
    do_op(0, 2'b11, 0, 32'h102, 32'h0, 5'd1, 0, 1, 1, 32'h1);
    // Response in the last wait cycle still wins over the timeout
    do_op(0, 2'b10, 0, 32'h300, 32'h0, 5'd11, 0, TO, 1, 32'h0BAD_F00D);
    // Timeout, then a late response in IDLE
    do_op(0, 2'b10, 0, 32'h400, 32'h0, 5'd12, 0, 1, 0, 32'h0);
    dmem_if.rsp_valid = 1; dmem_if.rsp_rdata = 32'h1111_2222;
    tick();
    dmem_if.rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("late_rsp_quiet", {30'd0, wb_valid, done}, 32'd0);
      tick();
    end

    // Reset while waiting for a response
    req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 32'h40; req_rd = 5'd3;
    tick();
    req_valid = 0;
    dmem_if.req_ready = 1;
    tick();
    dmem_if.req_ready = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    dmem_if.rsp_valid = 1; dmem_if.rsp_rdata = 32'hCAFE_F00D;
    check_idle_outputs("rst_wait");
    tick();
    dmem_if.rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_wait_quiet", {29'd0, wb_valid, done, exc_valid}, 32'd0);
      tick();
    end
    do_op(0, 2'b00, 0, 32'h41, 32'h0, 5'd21, 0, 1, 1, 32'h0000_F100);

    // Random mix, mostly aligned
    for (int n = 0; n < 40; n++) begin
      rsz = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra = ra & ~(32'(m_nbytes(rsz)) - 32'd1);
      do_op(1'($urandom), rsz, 1'($urandom), ra, $urandom, 5'($urandom),
            $urandom_range(0, 3), $urandom_range(1, TO), $urandom_range(0, 5) != 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
